// File: rtl/gpr_writeback_buffer.sv
// gpr_writeback_buffer: in-order FIFO of GPR writebacks feeding the single register-file
// write port, with combinational read-hazard flags over all pending entries.
module gpr_writeback_buffer #(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_valid,
    output logic            push_ready,
    input  logic [2:0]      push_sel,
    input  logic [15:0]     push_val,
    input  logic            push_is_8_bit,
    input  logic            wr_grant,
    output logic            wr_en,
    output logic [2:0]      wr_sel,
    output logic [15:0]     wr_val,
    output logic            wr_is_8_bit,
    input  logic            flush,
    input  logic [1:0][2:0] q_sel,
    input  logic            q_is_8_bit,
    output logic [1:0]      hazard,
    output logic            empty
);
    localparam int AW = $clog2(DEPTH);

    logic [2:0]    sel_q [DEPTH];
    logic [15:0]   val_q [DEPTH];
    logic          w8_q  [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, off;
    logic [AW:0]   count_q, count_d;
    logic          push;

    // Byte registers AL..BH collapse onto their containing word register.
    function automatic logic [2:0] phys(input logic [2:0] sel, input logic is8);
        return is8 ? {1'b0, sel[1:0]} : sel;
    endfunction

    assign empty       = count_q == '0;
    assign push_ready  = count_q != (AW+1)'(DEPTH);
    assign push        = push_valid & push_ready & ~flush;
    assign wr_en       = ~empty & wr_grant & ~flush;
    assign wr_sel      = sel_q[rd_ptr_q];
    assign wr_val      = val_q[rd_ptr_q];
    assign wr_is_8_bit = w8_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(wr_en);
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(wr_en);
    end

    // Validity comes from the slot's distance to the head, so stale slots never match.
    always_comb begin
        hazard = '0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr_q;
            for (int p = 0; p < 2; p++)
                hazard[p] = hazard[p] | (({1'b0, off} < count_q) &&
                            (phys(sel_q[i], w8_q[i]) == phys(q_sel[p], q_is_8_bit)));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sel_q[i] <= '0;
                val_q[i] <= '0;
                w8_q[i]  <= 1'b0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                sel_q[wr_ptr_q] <= push_sel;
                val_q[wr_ptr_q] <= push_val;
                w8_q[wr_ptr_q]  <= push_is_8_bit;
            end
        end
    end
endmodule

// File: tb/tb_gpr_writeback_buffer.sv
// tb_gpr_writeback_buffer: directed plus random stimulus against a queue-based model of the
// writeback buffer; every output is compared on the falling edge.
module tb_gpr_writeback_buffer;
    localparam int DEPTH = 4;

    logic            clk = 0;
    logic            reset = 0;
    logic            push_valid = 0, push_is_8_bit = 0, wr_grant = 0, flush = 0, q_is_8_bit = 0;
    logic [2:0]      push_sel = 0;
    logic [15:0]     push_val = 0;
    logic [1:0][2:0] q_sel = '0;
    logic            push_ready, wr_en, wr_is_8_bit, empty;
    logic [2:0]      wr_sel;
    logic [15:0]     wr_val;
    logic [1:0]      hazard;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] val;
        logic        w8;
    } ent_t;
    ent_t mq[$];

    gpr_writeback_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .push_valid(push_valid), .push_ready(push_ready),
        .push_sel(push_sel), .push_val(push_val), .push_is_8_bit(push_is_8_bit),
        .wr_grant(wr_grant), .wr_en(wr_en), .wr_sel(wr_sel), .wr_val(wr_val),
        .wr_is_8_bit(wr_is_8_bit), .flush(flush), .q_sel(q_sel), .q_is_8_bit(q_is_8_bit),
        .hazard(hazard), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] phys(input logic [2:0] sel, input logic is8);
        return is8 ? {1'b0, sel[1:0]} : sel;
    endfunction

    task automatic check_outputs();
        logic [1:0] hz;
        hz = '0;
        foreach (mq[k])
            for (int p = 0; p < 2; p++)
                if (phys(mq[k].sel, mq[k].w8) == phys(q_sel[p], q_is_8_bit)) hz[p] = 1'b1;
        chk("empty", empty, mq.size() == 0);
        chk("push_ready", push_ready, mq.size() != DEPTH);
        chk("wr_en", wr_en, mq.size() > 0 && wr_grant && !flush && reset);
        chk("hazard", hazard, hz);
        if (mq.size() > 0) begin
            chk("wr_sel", wr_sel, mq[0].sel);
            chk("wr_val", wr_val, mq[0].val);
            chk("wr_is_8_bit", wr_is_8_bit, mq[0].w8);
        end
    endtask

    task automatic cycle();
        bit pr;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        pr = mq.size() != DEPTH;
        if (!reset || flush) mq.delete();
        else begin
            if (mq.size() > 0 && wr_grant) void'(mq.pop_front());
            if (push_valid && pr) mq.push_back('{push_sel, push_val, push_is_8_bit});
        end
        #1;
    endtask

    task automatic drive(input logic pv, input logic [2:0] s, input logic [15:0] v, input logic w8,
                         input logic g, input logic f);
        push_valid = pv; push_sel = s; push_val = v; push_is_8_bit = w8;
        wr_grant = g; flush = f;
    endtask

    initial begin
        repeat (2) cycle();
        reset = 1;
        #1;
        // Single 16-bit write drains the following cycle
        drive(1, 3, 16'h1234, 0, 1, 0); cycle();
        drive(0, 0, 0, 0, 1, 0);        cycle(); cycle();
        // Fill with grant low, refuse the fifth push, then drain in order
        for (int i = 0; i < 5; i++) begin drive(1, 3'(i), 16'hA000 + 16'(i), 0, 0, 0); cycle(); end
        drive(1, 7, 16'hBEEF, 0, 1, 0); cycle();
        drive(1, 6, 16'hCAFE, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 0); repeat (5) cycle();
        // AH pending aliases AX, and AL/AH queries both hit it
        drive(1, 4, 16'h0055, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0); q_sel[0] = 0; q_sel[1] = 1; q_is_8_bit = 0; cycle();
        q_sel[0] = 4; q_sel[1] = 0; q_is_8_bit = 1; cycle();
        drive(0, 0, 0, 0, 1, 0); cycle(); cycle();
        // Flush with a concurrent push and grant
        drive(1, 1, 16'h1111, 0, 0, 0); cycle();
        drive(1, 2, 16'h2222, 0, 0, 0); cycle();
        drive(1, 5, 16'h5555, 1, 1, 1); cycle();
        drive(0, 0, 0, 0, 1, 0); cycle(); cycle();
        // Asynchronous reset mid-cycle with three entries pending
        for (int i = 0; i < 3; i++) begin drive(1, 3'(i + 1), 16'h7700 + 16'(i), 0, 0, 0); cycle(); end
        drive(0, 0, 0, 0, 1, 0); q_sel[0] = 1; q_sel[1] = 2; q_is_8_bit = 0;
        #2 reset = 0;
        #1;
        mq.delete();
        check_outputs();
        chk("rst_wr_sel", wr_sel, 0);
        chk("rst_wr_val", wr_val, 0);
        cycle();
        reset = 1;
        cycle(); cycle();
        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom), 16'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            q_sel[0] = 3'($urandom); q_sel[1] = 3'($urandom); q_is_8_bit = 1'($urandom);
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/gpr_writeback_buffer.md
Name: gpr_writeback_buffer

Overview:
- Small FIFO between the execute/microcode writeback path and the GPR register file's single write port.
- Accepts register writebacks (8- or 16-bit), holds them in order, and drains one per cycle when the write port is granted.
- Flags read hazards: a pending write aliases a register about to be read, so the sequencer stalls the read until the write drains.

Parameters:
- DEPTH, 4, number of buffered writebacks (power of two, >=2).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low (0 = in reset); clears all state immediately.
- push_valid  input  1  writeback offered this cycle.
- push_ready  output  1  buffer can accept (not full).
- push_sel  input  3  destination register encoding (8086 reg field).
- push_val  input  16  write data; only [7:0] meaningful when push_is_8_bit.
- push_is_8_bit  input  1  byte write: sel[2]=0 low byte, sel[2]=1 high byte of reg {0,sel[1:0]}.
- wr_grant  input  1  register-file write port available this cycle.
- wr_en  output  1  write strobe to register file.
- wr_sel  output  3  head entry sel.
- wr_val  output  16  head entry value.
- wr_is_8_bit  output  1  head entry width; the sequencer muxes this onto the register file's is_8_bit when wr_en=1.
- flush  input  1  synchronous discard of all pending entries.
- q_sel  input  3x2  two read-port selects being issued (port 0, port 1).
- q_is_8_bit  input  1  width of the read query.
- hazard  output  2  hazard[p]=1 if any pending entry aliases q_sel[p].
- empty  output  1  no pending entries.

Behaviour:
- State: DEPTH-entry array {sel, val, is_8_bit}, rd_ptr and wr_ptr (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits).
- Reset (reset=0):
  - count=0, pointers=0.
  - Outputs: wr_en=0, push_ready=1, empty=1, hazard=2'b00.
  - wr_sel/wr_val/wr_is_8_bit: don't-care; reset entry storage to 0 so they read 0.
  - Reset mid-operation discards all pending entries.
- push_ready = (count != DEPTH).
- Push accepted when push_valid & push_ready & ~flush. The entry is written at wr_ptr and wr_ptr increments.
- No fall-through: an entry pushed in cycle N appears on wr_* at N+1 at the earliest.
- wr_* outputs are driven combinationally from the head entry (rd_ptr). wr_en = ~empty & wr_grant & ~flush.
- Pop: when wr_en=1, rd_ptr increments at the clock edge. The register file latches the write the same edge.
- Simultaneous push and pop:
  - Not full: count unchanged, both pointers advance.
  - Full: push_ready=0, so the push is refused even though a pop occurs (no same-cycle slot reuse).
- Ordering: strict FIFO. Writes to the same register drain in push order, and the last write wins in the register file.
- flush=1:
  - wr_en forced 0.
  - At the edge: count=0, pointers=0.
  - A push offered in the same cycle is dropped.
- Physical register mapping:
  - 16-bit entry/query: phys = sel.
  - 8-bit: phys = {0,sel[1:0]}.
- Alias rule: an 8-bit and a 16-bit access alias when their phys match. Examples: AH (sel 4, 8-bit) aliases AX (sel 0, 16-bit). AL and AH do alias each other.
- hazard[p] = OR over valid entries of (phys(entry) == phys(q_sel[p], q_is_8_bit)). The result is combinational.
- Hazard includes the head entry even when it is draining this cycle. The register-file bypass covers the exact-match case, but the sequencer treats hazard conservatively.
- Entry validity is derived from count/pointers only. Stale storage beyond count must never raise hazard.
- empty = (count == 0).

Test Plan:
- Reset with pushes pending (3 entries, reset pulsed low mid-cycle) -> immediately empty=1, wr_en=0, push_ready=1, hazard=00; after release, no stale write issued.
- Push sel=3 val=16'h1234 16-bit with wr_grant=1 -> next cycle wr_en=1, wr_sel=3, wr_val=16'h1234; following cycle empty=1.
- wr_grant=0, push 4 entries (sel 0..3, vals 16'hA000..16'hA003) -> push_ready=0 after 4th; 5th push ignored; grant asserted -> drains A000, A001, A002, A003 in order on consecutive cycles, then empty.
- Full buffer, push_valid=1 and wr_grant=1 same cycle -> one pop, push refused, count=DEPTH-1; next cycle push accepted.
- Pending 8-bit write sel=4 (AH); query q_sel={0,1} 16-bit -> hazard=2'b01; query q_sel={4,0} 8-bit -> hazard=2'b11 (AL and AH both map to phys 0); after drain -> 00.
- 2 entries pending, flush=1 with push_valid=1 and wr_grant=1 -> wr_en=0 that cycle, next cycle empty=1, hazard=00, no write issued.
